// File: rtl/bcd_pattern_recorder.sv
// bcd_pattern_recorder: splits a clamped 7-bit value stream into constant-value segments and
// writes each one as a 4-nibble BCD record. Define REC_ZERO_TERM_EN for a zero terminator record.
module bcd_pattern_recorder (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] in,
  input  logic       stop,
  output logic [7:0] addr,
  output logic [3:0] data,
  output logic       s_,
  output logic       mw_,
  output logic       done,
  output logic       full,
  output logic       ovf
);
  typedef enum logic [3:0] {
    W_IDLE, SET0, STB0, SET1, STB1, SET2, STB2, SET3, STB3, W_DONE
  } wstate_t;

  wstate_t     state, state_next;
  logic [6:0]  in_clamped, cur, cnt;
  logic        started, recording;
  logic        seg_close, push_ok, pop, load_term, term_go;
  logic [13:0] fifo_mem [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  fifo_cnt;
  logic        fifo_full, fifo_empty;
  logic [13:0] wr_rec;
  logic [7:0]  bcd_val, bcd_dur;
  logic [3:0]  nib, data_hold;
  logic        is_active, is_stb;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] t;
    logic [6:0] r;
    t = 4'd0;
    r = v;
    for (int i = 0; i < 9; i++) begin
      if (r >= 7'd10) begin
        r = r - 7'd10;
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

  assign in_clamped = (in > 7'd99) ? 7'd99 : in;
  assign seg_close  = recording && started && (stop || (in_clamped != cur) || (cnt == 7'd99));

  always_ff @(posedge clock) begin
    if (reset) begin
      started   <= 1'b0;
      recording <= 1'b1;
      cur       <= 7'd0;
      cnt       <= 7'd0;
    end else if (recording) begin
      if (stop) begin
        recording <= 1'b0;
      end else if (!started || seg_close) begin
        started <= 1'b1;
        cur     <= in_clamped;
        cnt     <= 7'd1;
      end else begin
        cnt <= cnt + 7'd1;
      end
    end
  end

  // Once the memory is full, closed segments never enter the FIFO and do not count as overflow.
  assign fifo_full  = (fifo_cnt == 2'd2);
  assign fifo_empty = (fifo_cnt == 2'd0);
  assign push_ok    = seg_close && !full && (!fifo_full || pop);

  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[wr_ptr] <= {cur, cnt};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      ovf      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      if (push_ok && !pop) fifo_cnt <= fifo_cnt + 2'd1;
      else if (!push_ok && pop) fifo_cnt <= fifo_cnt - 2'd1;
      if (seg_close && !full && fifo_full && !pop) ovf <= 1'b1;
    end
  end

`ifdef REC_ZERO_TERM_EN
  logic term_pending;
  always_ff @(posedge clock) begin
    if (reset) term_pending <= 1'b1;
    else if (load_term) term_pending <= 1'b0;
  end
  assign term_go = term_pending && !recording;
`else
  assign term_go = 1'b0;
`endif

  assign is_stb = (state == STB0) || (state == STB1) || (state == STB2) || (state == STB3);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_term  = 1'b0;
    case (state)
      W_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = SET0;
        end else if (!recording) begin
          if (term_go) begin
            load_term  = 1'b1;
            state_next = SET0;
          end else begin
            state_next = W_DONE;
          end
        end
      end
      SET0: state_next = STB0;
      STB0: state_next = SET1;
      SET1: state_next = STB1;
      STB1: state_next = SET2;
      SET2: state_next = STB2;
      STB2: state_next = SET3;
      SET3: state_next = STB3;
      STB3: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = SET0;
        end else if (term_go) begin
          load_term  = 1'b1;
          state_next = SET0;
        end else begin
          state_next = W_IDLE;
        end
      end
      W_DONE:  state_next = W_DONE;
      default: state_next = W_IDLE;
    endcase
    if (is_stb && (addr == 8'hFF)) begin
      pop        = 1'b0;
      load_term  = 1'b0;
      state_next = W_DONE;
    end
  end

  always_comb begin
    bcd_val   = to_bcd(wr_rec[13:7]);
    bcd_dur   = to_bcd(wr_rec[6:0]);
    is_active = 1'b1;
    nib       = data_hold;
    case (state)
      SET0, STB0: nib = bcd_val[3:0];
      SET1, STB1: nib = bcd_val[7:4];
      SET2, STB2: nib = bcd_dur[3:0];
      SET3, STB3: nib = bcd_dur[7:4];
      default:    is_active = 1'b0;
    endcase
  end

  assign s_   = ~is_active;
  assign mw_  = ~is_stb;
  assign data = nib;
  assign done = (state == W_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= W_IDLE;
      addr      <= 8'd0;
      full      <= 1'b0;
      data_hold <= 4'd0;
      wr_rec    <= 14'd0;
    end else begin
      state <= state_next;
      if (is_active) data_hold <= nib;
      if (is_stb) begin
        addr <= addr + 8'd1;
        if (addr == 8'hFF) full <= 1'b1;
      end
      if (pop) wr_rec <= fifo_mem[rd_ptr];
      else if (load_term) wr_rec <= 14'd0;
    end
  end
endmodule

// File: tb/tb_bcd_pattern_recorder.sv
// Scoreboard bench for bcd_pattern_recorder: expected memory writes are queued with the stimulus
// and checked by a strobe monitor; scenario tasks check status outputs inline.
module tb_bcd_pattern_recorder;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] in_v  = 7'd0;
  logic       stop  = 1'b0;
  logic [7:0] addr;
  logic [3:0] data;
  logic       s_, mw_, done, full, ovf;

  bcd_pattern_recorder dut (
    .clock(clock), .reset(reset), .in(in_v), .stop(stop),
    .addr(addr), .data(data), .s_(s_), .mw_(mw_),
    .done(done), .full(full), .ovf(ovf)
  );

  always #5 clock = ~clock;

`ifdef REC_ZERO_TERM_EN
  localparam int TERM = 1;
`else
  localparam int TERM = 0;
`endif

  int          total = 0;
  int          bad   = 0;
  int          wcount = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_e;
  logic [3:0]  mem [256];

  always @(negedge clock) begin
    if (!reset && s_ === 1'b0 && mw_ === 1'b0) begin
      mem[addr] = data;
      wcount++;
      if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        total++;
        if ({addr, data} !== exp_e) begin
          bad++;
          $display("FAIL mem_write: got addr=%0d data=%0d expected addr=%0d data=%0d",
                   addr, data, exp_e[11:4], exp_e[3:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 4'hF;
    wcount = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stop  = 1'b0;
    cyc();
    cyc();
    clear_mem();
    reset = 1'b0;
  endtask

  task automatic push_rec(input int base, input int v, input int d);
    int nib[4];
    nib[0] = v % 10; nib[1] = v / 10; nib[2] = d % 10; nib[3] = d / 10;
    for (int k = 0; k < 4; k++) exp_q.push_back({8'(base + k), 4'(nib[k])});
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    total++; if (addr !== 8'd0) begin bad++; $display("FAIL reset_addr: got %0d expected 0", addr); end
    total++; if (data !== 4'd0) begin bad++; $display("FAIL reset_data: got %0d expected 0", data); end
    total++; if (s_ !== 1'b1) begin bad++; $display("FAIL reset_s: got %b expected 1", s_); end
    total++; if (mw_ !== 1'b1) begin bad++; $display("FAIL reset_mw: got %b expected 1", mw_); end
    total++; if ({done, full, ovf} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b expected 000", {done, full, ovf}); end
  endtask

  task automatic test_basic();
    int n;
    do_reset();
    push_rec(0, 42, 5);
    push_rec(4, 7, 3);
    if (TERM != 0) push_rec(8, 0, 0);
    in_v = 7'd42; repeat (5) cyc();
    in_v = 7'd7;  repeat (3) cyc();
    stop = 1'b1;  cyc();
    stop = 1'b0;
    wait_done(200, n);
    total++; if (n !== 15 + 8 * TERM) begin bad++; $display("FAIL basic_done_latency: got %0d expected %0d", n, 15 + 8 * TERM); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done: got %b expected 1", done); end
    total++; if (addr !== 8'(8 + 4 * TERM)) begin bad++; $display("FAIL basic_addr: got %0d expected %0d", addr, 8 + 4 * TERM); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf: got %b expected 0", ovf); end
    total++; if (wcount !== 8 + 4 * TERM) begin bad++; $display("FAIL basic_writes: got %0d expected %0d", wcount, 8 + 4 * TERM); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL basic_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_saturate(input int v_in, input int n_cyc);
    int n, rem, a, d, c;
    do_reset();
    c = (v_in > 99) ? 99 : v_in;
    rem = n_cyc;
    a = 0;
    while (rem > 0) begin
      d = (rem > 99) ? 99 : rem;
      push_rec(a, c, d);
      a += 4;
      rem -= d;
    end
    if (TERM != 0) begin push_rec(a, 0, 0); a += 4; end
    in_v = 7'(v_in);
    repeat (n_cyc) cyc();
    stop = 1'b1; cyc();
    stop = 1'b0;
    wait_done(300, n);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL sat_done: got %b expected 1", done); end
    total++; if (addr !== 8'(a)) begin bad++; $display("FAIL sat_addr: got %0d expected %0d", addr, a); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL sat_ovf: got %b expected 0", ovf); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL sat_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    int n, nrec, b;
    logic ok;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      in_v = (i % 2 == 0) ? 7'd1 : 7'd2;
      cyc();
    end
    stop = 1'b1; cyc();
    stop = 1'b0;
    wait_done(400, n);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL ovf_done: got %b expected 1", done); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
    total++; if (wcount % 4 !== 0) begin bad++; $display("FAIL ovf_whole_records: got %0d writes expected multiple of 4", wcount); end
    nrec = wcount / 4;
    total++; if (nrec < 3 + TERM) begin bad++; $display("FAIL ovf_record_count: got %0d expected at least %0d", nrec, 3 + TERM); end
    total++; if (mem[0] !== 4'd1 || mem[4] !== 4'd2) begin bad++; $display("FAIL ovf_first_values: got %0d,%0d expected 1,2", mem[0], mem[4]); end
    for (int r = 0; r < nrec; r++) begin
      b = 4 * r;
      if (TERM != 0 && r == nrec - 1)
        ok = (mem[b] == 0) && (mem[b+1] == 0) && (mem[b+2] == 0) && (mem[b+3] == 0);
      else
        ok = (mem[b] == 1 || mem[b] == 2) && (mem[b+1] == 0) && (mem[b+2] == 1) && (mem[b+3] == 0);
      total++;
      if (ok !== 1'b1) begin
        bad++;
        $display("FAIL ovf_record%0d: got %0d,%0d,%0d,%0d expected value 1/2 duration 1", r, mem[b], mem[b+1], mem[b+2], mem[b+3]);
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int v = 0; v < 64; v++) push_rec(4 * v, v, 10);
    for (int v = 0; v < 64; v++) begin
      in_v = 7'(v);
      repeat (10) cyc();
    end
    in_v = 7'd64; cyc();
    total++; if (full !== 1'b0) begin bad++; $display("FAIL full_early: got %b expected 0", full); end
    repeat (8) cyc();
    total++; if ({s_, mw_, addr} !== {2'b00, 8'd255}) begin bad++; $display("FAIL full_last_strobe: got s=%b mw=%b addr=%0d expected 0 0 255", s_, mw_, addr); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL full_before_wrap: got %b expected 0", full); end
    cyc();
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_set: got %b expected 1", full); end
    total++; if (addr !== 8'd0) begin bad++; $display("FAIL full_wrap_addr: got %0d expected 0", addr); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL full_done: got %b expected 1", done); end
    in_v = 7'd65; repeat (10) cyc();
    in_v = 7'd3;  repeat (3) cyc();
    stop = 1'b1; cyc();
    stop = 1'b0; repeat (12) cyc();
    total++; if (wcount !== 256) begin bad++; $display("FAIL full_writes: got %0d expected 256", wcount); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL full_ovf: got %b expected 0", ovf); end
    total++; if ({full, done, addr} !== {2'b11, 8'd0}) begin bad++; $display("FAIL full_hold: got full=%b done=%b addr=%0d expected 1 1 0", full, done, addr); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL full_pending: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_write();
    int n;
    do_reset();
    in_v = 7'd5; repeat (3) cyc();
    in_v = 7'd6; cyc();
    repeat (4) cyc();
    total++; if ({s_, mw_, addr} !== {2'b00, 8'd1}) begin bad++; $display("FAIL mid_stb1: got s=%b mw=%b addr=%0d expected 0 0 1", s_, mw_, addr); end
    reset = 1'b1; cyc();
    total++; if ({s_, mw_, addr} !== {2'b11, 8'd0}) begin bad++; $display("FAIL mid_abort: got s=%b mw=%b addr=%0d expected 1 1 0", s_, mw_, addr); end
    clear_mem();
    push_rec(0, 8, 4);
    if (TERM != 0) push_rec(4, 0, 0);
    in_v = 7'd8;
    reset = 1'b0;
    repeat (4) cyc();
    stop = 1'b1; cyc();
    stop = 1'b0;
    wait_done(200, n);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL mid_done: got %b expected 1", done); end
    total++; if (addr !== 8'(4 + 4 * TERM)) begin bad++; $display("FAIL mid_addr: got %0d expected %0d", addr, 4 + 4 * TERM); end
    total++; if (wcount !== 4 + 4 * TERM) begin bad++; $display("FAIL mid_writes: got %0d expected %0d", wcount, 4 + 4 * TERM); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL mid_pending: got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate(120, 100);
    test_saturate(55, 250);
    test_overflow();
    test_full();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_pattern_recorder.md
# bcd_pattern_recorder

Records the time course of a 7-bit value into the 256-nibble BCD pattern memory. It produces the record format that the pattern player consumes. Each period during which the sampled value stays constant becomes one 4-nibble record (value units, value tens, duration units, duration tens), written at consecutive addresses through the memory's active-low select/write strobes. A 2-entry record FIFO decouples segment detection from the 8-cycle memory write.

## Interface
- No parameters; FIFO depth 2, memory depth 256 nibbles, and maximum duration 99 are fixed.
- clock  in  1  sole clock; everything updates on the rising edge
- reset  in  1  synchronous, active-high reset
- in  in  7  value to record, sampled every edge; values >99 are clamped to 99
- stop  in  1  level; sampled high while recording, closes the open segment and ends recording
- addr  out  8  memory nibble address
- data  out  4  BCD digit being written
- s_  out  1  memory select, active low
- mw_  out  1  memory write strobe, active low
- done  out  1  recording finished, all writes complete
- full  out  1  memory exhausted (256 nibbles written)
- ovf  out  1  sticky; a closed record was dropped because the FIFO was full

## Operation
- Recorder, segment side:
  - First edge after reset deasserts: CUR=clamp(in), CNT=1.
  - Each later edge: if clamp(in)==CUR and CNT<99, CNT+=1.
  - Otherwise close the segment: push {CUR,CNT} into the FIFO, then CUR=clamp(in), CNT=1.
  - Edge with stop=1 while recording: push {CUR,CNT}, then stop recording permanently until reset. in is ignored afterwards.
  - Push with FIFO full and no pop on the same edge: record is dropped, ovf=1.
  - Push and pop on the same edge are always accepted.
- Writer FSM states: W_IDLE, SET0, STB0, SET1, STB1, SET2, STB2, SET3, STB3, W_DONE.
  - W_IDLE with FIFO non-empty: pop into the writer register, go to SET0.
  - SETk: s_=0, mw_=1, addr=current, data=nibble k.
  - STBk: s_=0, mw_=0, addr and data unchanged; addr+=1 at the end of STBk.
  - Nibble order: 0=value%10, 1=value/10, 2=duration%10, 3=duration/10. Conversion is combinational binary-to-BCD for 0..99.
  - After STB3, if the FIFO is non-empty, pop and go straight to SET0 (back-to-back). Otherwise go to W_IDLE.
- Full:
  - The STB of address 255 wraps addr to 0 and sets full=1; the writer goes to W_DONE.
  - Further closed records are discarded silently; ovf is not set.
  - A record cut off mid-write by full never happens, because 256 is a multiple of 4.
- done=1 when the writer is in W_DONE. W_DONE is entered on full, or when recording has stopped and the FIFO and writer are empty.
- Outside SET/STB: s_=1, mw_=1, data holds its last value.

## Timing
- Reset values:
  - Outputs: addr=0, data=0, s_=1, mw_=1, done=0, full=0, ovf=0.
  - Internal: FIFO empty, writer in W_IDLE, recording armed.
- Reset high during any state takes effect at the next edge and aborts an in-progress write. A partially written record is not repeated.
- Latency, with a record closed at edge E and the FIFO/writer idle:
  - SET0 is visible after E+1.
  - The first mw_ low is after E+2.
  - The last strobe (STB3) spans E+8 to E+9.
- 8 cycles per record. Sustained segments shorter than 8 cycles overflow the FIFO.
- CNT saturation: a constant value for 250 cycles gives records of 99, 99 and 52 cycles, all with the same value.
- Simultaneous stop and value change on the same edge: a single push of the old segment. The new value is not recorded.

## Configuration
- REC_ZERO_TERM_EN defined:
  - After stop, once the FIFO drains and full=0, the writer emits one extra terminator record {0,0,0,0}, which takes 8 cycles, then enters W_DONE.
  - If the terminator write makes the memory full, full=1.
- REC_ZERO_TERM_EN undefined: no terminator is written; W_DONE is entered directly after the drain.

## Test plan
- Reset, then in=42 for 5 cycles, then in=7, stop asserted 3 cycles later -> mem[0..3]=2,4,5,0 and mem[4..7]=7,0,3,0; done=1; addr=8; ovf=0.
- in=120 constant for 100 cycles, then stop -> first record 9,9,9,9 (clamped value, duration 99); second record 9,9,1,0.
- in toggling between 1 and 2 every cycle for 40 cycles -> ovf=1. Every stored record has duration 1, and stored values alternate in order except at the dropped positions.
- 64 back-to-back 10-cycle segments with in=0..63 -> full=1 after the 256th strobe; addr=0; the 65th segment is not written; ovf=0; done=1.
- reset asserted during STB1 of the first record -> s_=1, mw_=1 and addr=0 at the next edge; recording restarts from addr 0.
- With REC_ZERO_TERM_EN defined: the scenario of the first test leaves mem[8..11]=0,0,0,0, with done one record (8 cycles) later than without the macro.
